// File: rtl/module_top.sv
// module_top: Hamming(7,4)-corrected nibble and reference nibble on a two-digit multiplexed seven-segment display
module module_top (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i,
    input  logic [6:0] e,
    output logic [6:0] d,
    output logic       x,
    output logic       y
);
    logic [3:0]  i_m, i_s;
    logic [6:0]  e_m, e_s;
    logic [15:0] cnt;
    logic [2:0]  s;
    logic [6:0]  c;
    logic [3:0]  n;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'ha: seg = 7'h08;
            4'hb: seg = 7'h03;
            4'hc: seg = 7'h46;
            4'hd: seg = 7'h21;
            4'he: seg = 7'h06;
            default: seg = 7'h0e;
        endcase
    endfunction

    // syndrome flips the addressed codeword position, then pick the nibble for the active digit
    always_comb begin
        s = {e_s[3] ^ e_s[4] ^ e_s[5] ^ e_s[6],
             e_s[1] ^ e_s[2] ^ e_s[5] ^ e_s[6],
             e_s[0] ^ e_s[2] ^ e_s[4] ^ e_s[6]};
        c = (s == 3'd0) ? e_s : e_s ^ (7'd1 << (s - 3'd1));
        n = cnt[15] ? i_s : {c[6], c[5], c[4], c[2]};
    end

    // input synchronizers, free-running refresh counter and registered display drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_m <= 4'd0;
            i_s <= 4'd0;
            e_m <= 7'd0;
            e_s <= 7'd0;
            cnt <= 16'd0;
            d   <= 7'h7f;
            x   <= 1'b0;
            y   <= 1'b0;
        end else begin
            i_m <= i;
            i_s <= i_m;
            e_m <= e;
            e_s <= e_m;
            cnt <= cnt + 16'd1;
            d   <= seg(n);
            x   <= ~cnt[15];
            y   <= cnt[15];
        end
    end
endmodule

// File: tb/tb_module_top.sv
// tb_module_top: randomized bench for module_top against a behavioural display/decoder model
module tb_module_top;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i;
    logic [6:0] e;
    logic [6:0] d;
    logic       x;
    logic       y;

    int total = 0;
    int bad = 0;

    module_top dut (.clk(clk), .rst_n(rst_n), .i(i), .e(e), .d(d), .x(x), .y(y));

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic logic [3:0] decode(input logic [6:0] w);
        logic [6:0] v;
        int syn;
        v = w;
        syn = 0;
        for (int b = 0; b < 3; b++) begin
            logic p;
            p = 1'b0;
            for (int k = 1; k <= 7; k++)
                if (((k >> b) & 1) == 1) p = p ^ v[k-1];
            if (p) syn = syn + (1 << b);
        end
        if (syn != 0) v[syn-1] = ~v[syn-1];
        return {v[6], v[5], v[4], v[2]};
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic [6:0] w;
        w = 7'd0;
        w[2] = nib[0];
        w[4] = nib[1];
        w[5] = nib[2];
        w[6] = nib[3];
        for (int b = 0; b < 3; b++) begin
            logic p;
            p = 1'b0;
            for (int k = 1; k <= 7; k++)
                if (((k >> b) & 1) == 1) p = p ^ w[k-1];
            w[(1 << b) - 1] = p;
        end
        return w;
    endfunction

    function automatic logic [6:0] rand_word();
        logic [6:0] w;
        int a, b;
        w = encode(4'($urandom_range(0, 15)));
        a = $urandom_range(0, 6);
        b = (a + $urandom_range(1, 6)) % 7;
        case ($urandom_range(0, 3))
            0: w = 7'($urandom_range(0, 127));
            1: ;
            2: w[a] = ~w[a];
            default: begin
                w[a] = ~w[a];
                w[b] = ~w[b];
            end
        endcase
        return w;
    endfunction

    // model: edge count since reset picks the digit; the value shown comes from inputs two edges back
    logic [10:0] hq [$];
    logic [10:0] h;
    logic [6:0]  ed;
    logic        ex, ey;
    bit          mv = 1'b0;
    int          kk = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            kk = 0;
            hq = '{11'd0, 11'd0};
            ed = 7'b1111111;
            ex = 1'b0;
            ey = 1'b0;
            mv = 1'b1;
        end else if (mv) begin
            kk++;
            hq.push_back({i, e});
            h = hq.pop_front();
            ey = (((kk - 1) % 65536) >= 32768);
            ex = !ey;
            ed = ey ? tbl[h[10:7]] : tbl[decode(h[6:0])];
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            total++;
            if (d !== ed || x !== ex || y !== ey) begin
                bad++;
                $display("FAIL model t=%0t got d=%b x=%b y=%b want d=%b x=%b y=%b", $time, d, x, y, ed, ex, ey);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        i = 4'd0;
        e = 7'd0;
        repeat (5) @(negedge clk);
        chk("rst_d", int'(d), 'h7f);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_x", int'(x), 1);
        chk("rel_y", int'(y), 0);
        chk("rel_d", int'(d), 'h40);
        i = 4'd1;
        e = 7'b0000111;
        repeat (2) @(negedge clk);
        chk("lat2_d", int'(d), 'h40);
        @(negedge clk);
        chk("valid1_d", int'(d), 'h79);
        e = 7'b0010111;
        repeat (3) @(negedge clk);
        chk("err5_d", int'(d), 'h79);
        e = 7'b1010100;
        repeat (3) @(negedge clk);
        chk("err1_d", int'(d), 'h03);
        e = 7'b0000100;
        repeat (3) @(negedge clk);
        chk("double_d", int'(d), 'h40);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) begin
                i = 4'($urandom_range(0, 15));
                e = rand_word();
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i = 4'ha;
        n = 0;
        while (n < 40000 && !y) begin
            @(negedge clk);
            n++;
            if (n % 64 == 0) e = rand_word();
        end
        chk("y_rise_edge", n, 32769);
        chk("y_d", int'(d), 'h08);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c % 16 == 0) e = rand_word();
        end
        chk("y_hold", int'(y), 1);
        chk("y_hold_d", int'(d), 'h08);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_d", int'(d), 'h7f);
        chk("midrst_x", int'(x), 0);
        chk("midrst_y", int'(y), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel2_x", int'(x), 1);
        chk("rel2_y", int'(y), 0);
        chk("rel2_d", int'(d), 'h40);
        n = 1;
        while (n < 40000 && !y) begin
            @(negedge clk);
            n++;
            if (n % 100 == 0) e = rand_word();
        end
        chk("y_rise2_edge", n, 32769);
        repeat (50) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
